div_8_seq: RTL
==============

# div_8_seq

Sequential unsigned divider: the inverse operation of the team's 8-bit combinational multiplier. It accepts a dividend and divisor over a valid/ready handshake, runs one restoring-division step per clock, and presents quotient and remainder over a second valid/ready handshake. It sits beside the multiplier in the arithmetic datapath, and bench checks close the loop: quotient × divisor + remainder == dividend.

## Interface
- Width, default 8: operand width in bits. Also the iteration count.
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- in_valid_i  input  1  operands valid.
- in_ready_o  output  1  divider can accept operands (state IDLE).
- dividend_i  input  Width  unsigned dividend.
- divisor_i  input  Width  unsigned divisor.
- out_valid_o  output  1  result valid (state DONE).
- out_ready_i  input  1  consumer takes the result.
- quotient_o  output  Width  unsigned quotient.
- remainder_o  output  Width  unsigned remainder.
- dbz_o  output  1  divide-by-zero flag, qualified by out_valid_o.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE: in_ready_o=1. On in_valid_i && in_ready_o, capture dividend_i and divisor_i, clear the partial remainder (Width+1 bits), clear the iteration counter, go to CALC.
  - CALC: each cycle:
    - R = {R[Width-1:0], next dividend MSB};
    - if R >= divisor: R -= divisor and shift in quotient bit 1, else shift in 0.
    - Counter counts 0..Width-1. On the step where the counter is Width-1, load quotient_o and remainder_o and go to DONE.
  - DONE: out_valid_o=1. On out_valid_o && out_ready_i, go to IDLE.
- Arithmetic:
  - The compare/subtract is done at Width+1 bits, so there is no overflow at divisor > 2^(Width-1).
  - Results satisfy quotient*divisor + remainder == dividend and remainder < divisor when divisor != 0.
- Divisor 0 in the natural algorithm yields quotient = all ones and remainder = dividend.
- Inputs are sampled only at the accept edge. Changes to dividend_i, divisor_i, or in_valid_i during CALC or DONE are ignored.
- quotient_o, remainder_o and dbz_o are registered. They change only on entry to DONE and hold their values until the next entry to DONE.
- in_valid_i and out_ready_i are don't-care outside IDLE and DONE respectively.

## Timing
- Reset (rst_ni low, asynchronous):
  - state IDLE, counter 0;
  - in_ready_o=1, out_valid_o=0;
  - quotient_o=0, remainder_o=0, dbz_o=0.
- Reset asserted mid-CALC or mid-DONE aborts the operation immediately. No result is emitted.
- Normal path:
  - Operands are accepted at edge E.
  - Iterations occur at edges E+1..E+Width.
  - out_valid_o is high from after edge E+Width.
  - With out_ready_i already high, the result handshake is at edge E+Width+1 and in_ready_o is high after it.
- Minimum initiation interval: Width+2 cycles (10 for Width=8).
- The result handshake and a new accept never happen on the same edge.
- Backpressure: DONE holds indefinitely while out_ready_i=0, with outputs stable.

## Configuration
- DIV_8_SEQ_DBZ_EN defined:
  - Divisor 0 at accept goes directly IDLE→DONE at the accept edge.
  - out_valid_o is high after edge E, with quotient_o = all ones, remainder_o = dividend, dbz_o=1.
  - Latency: 1 cycle.
- Not defined:
  - Divisor 0 takes the full Width-step CALC path and produces the same quotient and remainder values.
  - dbz_o is tied to 0.

## Test plan
- Reset, then check idle outputs: in_ready_o=1, out_valid_o=0, all results 0. Accept 200/7, out_ready_i=1 → out_valid_o after edge E+8, quotient 28, remainder 4, dbz_o=0; in_ready_o high after edge E+9.
- Boundaries, each → listed quotient/remainder:
  - 255/1 → 255/0
  - 255/255 → 1/0
  - 5/9 → 0/5
  - 255/128 → 1/127
  - 0/3 → 0/0
- Backpressure: hold out_ready_i=0 for 20 cycles after out_valid_o rises → outputs stable and in_ready_o=0 throughout. Release → single handshake. Change dividend_i during CALC → result unaffected.
- Divide by zero, 77/0:
  - with DIV_8_SEQ_DBZ_EN: out_valid_o one cycle after accept, quotient 255, remainder 77, dbz_o=1;
  - without it: out_valid_o after 8 iterations, quotient 255, remainder 77, dbz_o=0.
- Pull rst_ni low asynchronously mid-CALC (counter 4) → immediate reset values; no out_valid_o pulse. Next operation, 100/10, → 10/0.
- Random: 10,000 back-to-back operands with randomized out_ready_i → every result satisfies q*d + r == dividend and r < d.

Source files
------------

// File: rtl/div_8_seq.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on both sides.
// Optional DIV_8_SEQ_DBZ_EN: a zero divisor skips iteration and flags dbz_o.
//
// state | meaning
// IDLE  | ready for operands
// CALC  | one restoring step per cycle, Width cycles
// DONE  | result held until the consumer takes it
module div_8_seq #(
   parameter int Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] dividend_i,
   input  logic [Width-1:0] divisor_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] quotient_o,
   output logic [Width-1:0] remainder_o,
   output logic             dbz_o
);

   localparam int CntW = (Width > 1) ? $clog2(Width) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [Width-1:0] dvd_q, dvs_q, quo_q, quo_step;
   // The stored remainder is always < divisor, so only the shifted value needs Width+1 bits.
   logic [Width-1:0] rem_q;
   logic [Width:0]   rem_shift, rem_step;
   logic [CntW-1:0]  cnt_q;
   logic             accept, last_step, take_zero;

   assign accept    = in_valid_i && (state_q == IDLE);
   assign last_step = (state_q == CALC) && (cnt_q == CntLast);

`ifdef DIV_8_SEQ_DBZ_EN
   assign take_zero = accept && (divisor_i == '0);
`else
   assign take_zero = 1'b0;
`endif

   always_comb begin
      rem_shift = {rem_q, dvd_q[Width-1]};
      rem_step  = rem_shift;
      quo_step  = {quo_q[Width-2:0], 1'b0};
      if (rem_shift >= {1'b0, dvs_q}) begin
         rem_step = rem_shift - {1'b0, dvs_q};
         quo_step = {quo_q[Width-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_o = 1'b1;
            if (accept) state_d = take_zero ? DONE : CALC;
         end
         CALC: begin
            if (last_step) state_d = DONE;
         end
         DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         dvd_q <= dividend_i;
         dvs_q <= divisor_i;
         rem_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
      end else if (state_q == CALC) begin
         dvd_q <= {dvd_q[Width-2:0], 1'b0};
         rem_q <= rem_step[Width-1:0];
         quo_q <= quo_step;
         cnt_q <= cnt_q + 1'b1;
      end
   end

`ifdef DIV_8_SEQ_DBZ_EN
   logic dbz_q;
   assign dbz_o = dbz_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         quotient_o  <= '0;
         remainder_o <= '0;
         dbz_q       <= 1'b0;
      end else if (last_step) begin
         quotient_o  <= quo_step;
         remainder_o <= rem_step[Width-1:0];
         dbz_q       <= 1'b0;
      end else if (take_zero) begin
         quotient_o  <= '1;
         remainder_o <= dividend_i;
         dbz_q       <= 1'b1;
      end
   end
`else
   assign dbz_o = 1'b0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         quotient_o  <= '0;
         remainder_o <= '0;
      end else if (last_step) begin
         quotient_o  <= quo_step;
         remainder_o <= rem_step[Width-1:0];
      end
   end
`endif

endmodule
